// File: rtl/dcache_membridge.sv
// Memory-side bridge between the dcache burst port and a single-port SRAM.
// Sequences read/write bursts and hides the SRAM read latency behind a valid pipe.
module dcache_membridge #(
    parameter int ADDRBITS      = 32,
    parameter int DATABITS      = 32,
    parameter int SRAM_ADDRBITS = 9,
    parameter int RDLATENCY     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRBITS-1:0]      mem_addr,
    input  logic [DATABITS-1:0]      mem_in,
    output logic [DATABITS-1:0]      mem_out,
    output logic                     mem_out_valid,
    input  logic                     mem_rdreq,
    input  logic                     mem_wrreq,
    input  logic [15:0]              mem_burstlen,
    output logic                     mem_wr_ack,
    output logic                     mem_busy,
    output logic [SRAM_ADDRBITS-1:0] sram_addr,
    output logic [DATABITS-1:0]      sram_wdata,
    output logic                     sram_we,
    input  logic [DATABITS-1:0]      sram_rdata
);

    localparam int VW = RDLATENCY + 1;
    localparam logic [RDLATENCY:0] VLD_LAST = VW'(1) << RDLATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE
    } state_e;

    state_e                   state_q, state_d;
    logic [SRAM_ADDRBITS-1:0] addr_q, addr_d;
    logic [15:0]              rem_q, rem_d;
    logic [RDLATENCY:0]       vld_q, vld_d;
    logic [SRAM_ADDRBITS-1:0] sram_addr_q, sram_addr_d;
    logic [DATABITS-1:0]      sram_wdata_q, sram_wdata_d;
    logic                     sram_we_q, sram_we_d;
    logic [DATABITS-1:0]      mem_out_q, mem_out_d;
    logic                     mem_out_valid_q, mem_out_valid_d;
    logic                     wr_ack_q, wr_ack_d;

    logic [SRAM_ADDRBITS-1:0] base;
    logic [15:0]              len;
    logic                     push;
    logic                     unused_addr;

    assign base = mem_addr[SRAM_ADDRBITS+1:2];
    assign len  = (mem_burstlen == 16'd0) ? 16'd1 : mem_burstlen;
    assign unused_addr = ^{mem_addr[ADDRBITS-1:SRAM_ADDRBITS+2], mem_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_d    = 1'b0;
        wr_ack_d     = 1'b0;
        push         = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Write wins a tie; the first write word rides with the request.
                if (mem_wrreq) begin
                    sram_we_d    = 1'b1;
                    sram_addr_d  = base;
                    sram_wdata_d = mem_in;
                    wr_ack_d     = 1'b1;
                    addr_d       = base + 1'b1;
                    rem_d        = len - 16'd1;
                    state_d      = (len == 16'd1) ? S_IDLE : S_WRITE;
                end else if (mem_rdreq) begin
                    push        = 1'b1;
                    sram_addr_d = base;
                    addr_d      = base + 1'b1;
                    rem_d       = len - 16'd1;
                    state_d     = (len == 16'd1) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                push        = 1'b1;
                sram_addr_d = addr_q;
                addr_d      = addr_q + 1'b1;
                rem_d       = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final word is captured so busy drops with it.
                if (vld_q == VLD_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if (mem_wrreq) begin
                    sram_we_d    = 1'b1;
                    sram_addr_d  = addr_q;
                    sram_wdata_d = mem_in;
                    wr_ack_d     = 1'b1;
                    addr_d       = addr_q + 1'b1;
                    rem_d        = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = push;
        for (int i = 1; i <= RDLATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        mem_out_valid_d = vld_q[RDLATENCY];
        mem_out_d       = vld_q[RDLATENCY] ? sram_rdata : mem_out_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            vld_q           <= '0;
            sram_addr_q     <= '0;
            sram_wdata_q    <= '0;
            sram_we_q       <= 1'b0;
            mem_out_q       <= '0;
            mem_out_valid_q <= 1'b0;
            wr_ack_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            vld_q           <= vld_d;
            sram_addr_q     <= sram_addr_d;
            sram_wdata_q    <= sram_wdata_d;
            sram_we_q       <= sram_we_d;
            mem_out_q       <= mem_out_d;
            mem_out_valid_q <= mem_out_valid_d;
            wr_ack_q        <= wr_ack_d;
        end
    end

    assign mem_out       = mem_out_q;
    assign mem_out_valid = mem_out_valid_q;
    assign mem_wr_ack    = wr_ack_q;
    assign mem_busy      = (state_q != S_IDLE);
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;
    assign sram_we       = sram_we_q;

endmodule

// File: tb/tb_dcache_membridge.sv
// Bench for dcache_membridge: two instances (read latency 0 and 2) share stimulus,
// each with its own SRAM model and scoreboard queues.
module tb_dcache_membridge;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [15:0] blen;
        logic [31:0] dbase;
        int          stall_at;
        int          stall_len;
        int          exp_n;
        logic [8:0]  exp_a0;
    } vec_t;

    typedef struct packed {
        logic [31:0] data;
        logic [8:0]  addr;
        logic [31:0] cyc;
    } sb_t;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_in;
    logic        mem_rdreq;
    logic        mem_wrreq;
    logic [15:0] mem_burstlen;

    logic [31:0] m_out0, m_out1;
    logic        m_vld0, m_vld1;
    logic        ack0, ack1;
    logic        busy0, busy1;
    logic [8:0]  sa0, sa1;
    logic [31:0] wd0, wd1;
    logic        we0, we1;
    logic [31:0] rd0, rd1;

    logic [31:0] sram0 [512];
    logic [31:0] sram1 [512];
    logic [31:0] ref_mem [512];
    logic [8:0]  sa1_p1, sa1_p2;
    logic        mem_init = 1'b1;
    logic        quiet = 1'b0;

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;

    sb_t rdq0[$];
    sb_t rdq1[$];
    sb_t wrq0[$];
    sb_t wrq1[$];

    vec_t vecs[11];

    dcache_membridge #(
        .ADDRBITS(32), .DATABITS(32), .SRAM_ADDRBITS(9), .RDLATENCY(0)
    ) dut0 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(m_out0), .mem_out_valid(m_vld0), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_burstlen(mem_burstlen),
        .mem_wr_ack(ack0), .mem_busy(busy0), .sram_addr(sa0),
        .sram_wdata(wd0), .sram_we(we0), .sram_rdata(rd0)
    );

    dcache_membridge #(
        .ADDRBITS(32), .DATABITS(32), .SRAM_ADDRBITS(9), .RDLATENCY(2)
    ) dut1 (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_in(mem_in),
        .mem_out(m_out1), .mem_out_valid(m_vld1), .mem_rdreq(mem_rdreq),
        .mem_wrreq(mem_wrreq), .mem_burstlen(mem_burstlen),
        .mem_wr_ack(ack1), .mem_busy(busy1), .sram_addr(sa1),
        .sram_wdata(wd1), .sram_we(we1), .sram_rdata(rd1)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'h5a5a0000 + 32'(i);
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 512; i++) begin
                sram0[i] <= pat(i);
                sram1[i] <= pat(i);
            end
        end else begin
            if (we0) sram0[sa0] <= wd0;
            if (we1) sram1[sa1] <= wd1;
        end
        sa1_p1 <= sa1;
        sa1_p2 <= sa1_p1;
    end

    assign rd0 = sram0[sa0];
    assign rd1 = sram1[sa1_p2];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic [31:0] dout,
                       input logic we, input logic [8:0] sa,
                       input logic [31:0] wd, input logic ack);
        sb_t e;
        if (vld) begin
            if ((id == 0 && rdq0.size() == 0) || (id == 1 && rdq1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL rd%0d_unexpected: got valid %h want none", id, dout);
            end else begin
                if (id == 0) e = rdq0.pop_front();
                else e = rdq1.pop_front();
                chk($sformatf("rd%0d_data", id), dout, e.data);
                chk($sformatf("rd%0d_cycle", id), cyc, e.cyc);
            end
        end
        if (we) begin
            if ((id == 0 && wrq0.size() == 0) || (id == 1 && wrq1.size() == 0)) begin
                total++;
                bad++;
                $display("FAIL wr%0d_unexpected: got write %h want none", id, sa);
            end else begin
                if (id == 0) e = wrq0.pop_front();
                else e = wrq1.pop_front();
                chk($sformatf("wr%0d_addr", id), 32'(sa), 32'(e.addr));
                chk($sformatf("wr%0d_data", id), wd, e.data);
                chk($sformatf("wr%0d_cycle", id), cyc, e.cyc);
                chk($sformatf("wr%0d_ack", id), 32'(ack), 32'd1);
            end
        end else if (ack) begin
            total++;
            bad++;
            $display("FAIL ack%0d_stray: got ack 1 want 0", id);
        end
    endtask

    always @(negedge clk) begin
        if (!quiet) begin
            mon(0, m_vld0, m_out0, we0, sa0, wd0, ack0);
            mon(1, m_vld1, m_out1, we1, sa1, wd1, ack1);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl0"}, {28'd0, m_vld0, ack0, busy0, we0}, 32'd0);
        chk({tag, "_out0"}, m_out0, 32'd0);
        chk({tag, "_sa0"}, 32'(sa0), 32'd0);
        chk({tag, "_wd0"}, wd0, 32'd0);
        chk({tag, "_ctl1"}, {28'd0, m_vld1, ack1, busy1, we1}, 32'd0);
        chk({tag, "_out1"}, m_out1, 32'd0);
        chk({tag, "_sa1"}, 32'(sa1), 32'd0);
        chk({tag, "_wd1"}, wd1, 32'd0);
    endtask

    task automatic push_rd(input logic [8:0] a0, input int n);
        logic [8:0] a;
        for (int k = 0; k < n; k++) begin
            a = a0 + 9'(k);
            rdq0.push_back('{data: ref_mem[a], addr: a, cyc: cyc + 2 + 32'(k)});
            rdq1.push_back('{data: ref_mem[a], addr: a, cyc: cyc + 4 + 32'(k)});
        end
    endtask

    task automatic wait_idle(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy0 || busy1) && n < 300);
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL v%0d_timeout: got busy after %0d cycles want idle", idx, n);
        end
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_rdq0_left", idx), 32'(rdq0.size()), 32'd0);
        chk($sformatf("v%0d_rdq1_left", idx), 32'(rdq1.size()), 32'd0);
        chk($sformatf("v%0d_wrq0_left", idx), 32'(wrq0.size()), 32'd0);
        chk($sformatf("v%0d_wrq1_left", idx), 32'(wrq1.size()), 32'd0);
        rdq0.delete();
        rdq1.delete();
        wrq0.delete();
        wrq1.delete();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [8:0]  a;
        logic [31:0] d;
        @(negedge clk);
        mem_addr     = v.addr;
        mem_burstlen = v.blen;
        mem_rdreq    = v.rd;
        mem_wrreq    = v.wr;
        if (v.wr) begin
            for (int k = 0; k < v.exp_n; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    mem_rdreq = 1'b0;
                    if (k == v.stall_at) begin
                        mem_wrreq = 1'b0;
                        repeat (v.stall_len) @(negedge clk);
                    end
                    mem_wrreq = 1'b1;
                end
                a = v.exp_a0 + 9'(k);
                d = v.dbase + 32'(k);
                mem_in = d;
                ref_mem[a] = d;
                wrq0.push_back('{data: d, addr: a, cyc: cyc + 1});
                wrq1.push_back('{data: d, addr: a, cyc: cyc + 1});
            end
            @(negedge clk);
            mem_wrreq = 1'b0;
            mem_rdreq = 1'b0;
        end else begin
            push_rd(v.exp_a0, v.exp_n);
            @(negedge clk);
            mem_rdreq = 1'b0;
        end
        wait_idle(idx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        //            wr    rd    addr          blen    dbase         stall  n  a0
        vecs[0]  = '{1'b1, 1'b0, 32'h00000080, 16'd1, 32'h0fff0001, -1, 0, 1, 9'h020};
        vecs[1]  = '{1'b0, 1'b1, 32'h00000080, 16'd1, 32'h0,        -1, 0, 1, 9'h020};
        vecs[2]  = '{1'b1, 1'b0, 32'h00000180, 16'd8, 32'h0fff1001,  3, 2, 8, 9'h060};
        vecs[3]  = '{1'b0, 1'b1, 32'h00000180, 16'd8, 32'h0,        -1, 0, 8, 9'h060};
        vecs[4]  = '{1'b1, 1'b0, 32'h000007f8, 16'd4, 32'h0fff2001, -1, 0, 4, 9'h1fe};
        vecs[5]  = '{1'b0, 1'b1, 32'h000007f8, 16'd4, 32'h0,        -1, 0, 4, 9'h1fe};
        vecs[6]  = '{1'b1, 1'b1, 32'h00000200, 16'd2, 32'h0fff3001, -1, 0, 2, 9'h080};
        vecs[7]  = '{1'b1, 1'b0, 32'h00000240, 16'd0, 32'h0fff4001, -1, 0, 1, 9'h090};
        vecs[8]  = '{1'b0, 1'b1, 32'h00000240, 16'd0, 32'h0,        -1, 0, 1, 9'h090};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000200, 16'd3, 32'h0,        -1, 0, 3, 9'h080};
        vecs[10] = '{1'b0, 1'b1, 32'hfffff004, 16'd2, 32'h0,        -1, 0, 2, 9'h001};

        for (int i = 0; i < 512; i++) ref_mem[i] = pat(i);
        reset        = 1'b1;
        mem_addr     = '0;
        mem_in       = '0;
        mem_rdreq    = 1'b0;
        mem_wrreq    = 1'b0;
        mem_burstlen = '0;

        @(posedge clk);
        #1;
        mem_init = 1'b0;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Abort an 8-word read partway through with an async reset.
        @(negedge clk);
        quiet        = 1'b1;
        mem_addr     = 32'h00000100;
        mem_burstlen = 16'd8;
        mem_rdreq    = 1'b1;
        @(negedge clk);
        mem_rdreq = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("midreset");
        quiet = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("post_reset_busy", {30'd0, busy0, busy1}, 32'd0);

        for (int i = 6; i < 11; i++) run_vec(i, vecs[i]);

        // Read request pulsed while both instances sit in DRAIN.
        @(negedge clk);
        mem_addr     = 32'h00000180;
        mem_burstlen = 16'd4;
        mem_rdreq    = 1'b1;
        push_rd(9'h060, 4);
        @(negedge clk);
        mem_rdreq = 1'b0;
        repeat (3) @(negedge clk);
        mem_addr  = 32'h00000000;
        mem_rdreq = 1'b1;
        #1;
        chk("drain_busy", {30'd0, busy0, busy1}, 32'd3);
        @(negedge clk);
        mem_rdreq = 1'b0;
        wait_idle(99);
        repeat (8) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_membridge.md
Name: dcache_membridge

Overview:
- Downstream neighbour of dcache. Consumes the dcache memory-side burst interface (mem_addr, mem_in, mem_out, mem_out_valid, mem_rdreq, mem_wrreq, mem_burstlen) and drives a single-port word-addressed SRAM.
- Sequences read and write bursts with an address counter and a word counter.
- Hides a configurable SRAM read latency behind a valid pipeline.
- Reports busy and per-word write acknowledge back to the cache.

Parameters:
- ADDRBITS, 32, width of mem_addr.
- DATABITS, 32, data word width.
- SRAM_ADDRBITS, 9, SRAM word-address width; SRAM holds 2**SRAM_ADDRBITS words.
- RDLATENCY, 0, cycles from sram_addr presented to sram_rdata valid. Legal range 0..3; 0 means combinational read.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  in  ADDRBITS  burst byte base address; bits [1:0] ignored.
- mem_in  in  DATABITS  write data word, valid with mem_wrreq.
- mem_out  out  DATABITS  read data word.
- mem_out_valid  out  1  mem_out carries one burst word this cycle.
- mem_rdreq  in  1  read burst request, sampled in IDLE.
- mem_wrreq  in  1  write request / write word valid.
- mem_burstlen  in  16  words in burst; 0 treated as 1; sampled in IDLE only.
- mem_wr_ack  out  1  one-cycle pulse per write word committed to SRAM.
- mem_busy  out  1  high whenever state != IDLE.
- sram_addr  out  SRAM_ADDRBITS  SRAM word address (registered).
- sram_wdata  out  DATABITS  SRAM write data (registered).
- sram_we  out  1  SRAM write enable (registered).
- sram_rdata  in  DATABITS  SRAM read data.

Behaviour:
- Reset, asynchronous and any time including mid-burst:
  - state=IDLE.
  - mem_out=0, mem_out_valid=0, mem_wr_ack=0, mem_busy=0.
  - sram_addr=0, sram_wdata=0, sram_we=0.
  - Valid pipeline and counters cleared.
  - Aborted burst produces no further valid or ack.
- States: IDLE, READ, DRAIN, WRITE.
- IDLE:
  - Latch base=mem_addr[SRAM_ADDRBITS+1:2] and cnt=max(mem_burstlen,1).
  - mem_wrreq=1 -> WRITE, and the mem_in of this cycle is word 0.
  - Else mem_rdreq=1 -> READ.
  - Both high: write wins; the read is dropped and the requester must re-issue it.
- READ:
  - One SRAM address per cycle: base, base+1, …, for cnt cycles. Each issued address pushes a 1 into a valid shift register of depth RDLATENCY+1.
  - Request sampled at cycle T: sram_addr=base at T+1; word k appears on mem_out with mem_out_valid=1 at T+2+RDLATENCY+k.
  - After the last address is issued -> DRAIN.
- DRAIN: returns to IDLE on the cycle the last valid word is output. mem_busy drops the same cycle.
- WRITE:
  - Word accepted in cycle C (mem_wrreq=1) -> at C+1: sram_we=1, sram_addr=next address, sram_wdata=word, mem_wr_ack=1.
  - mem_wrreq=0 in WRITE stalls: no write, no ack, counter holds.
  - After cnt words accepted -> IDLE. sram_we for the last word is still asserted in the following cycle.
- Address counter wraps modulo 2**SRAM_ADDRBITS; no error flag.
- mem_rdreq/mem_wrreq while busy are ignored, except mem_wrreq as the word strobe in WRITE.
- mem_out holds its last value when mem_out_valid=0.
- Full-word transfers only; no byte lanes.
- mem_burstlen > 2**SRAM_ADDRBITS is legal and wraps, overwriting.

Test Plan:
- Reset mid-burst: start an 8-word read, assert reset at cycle 3 -> all outputs 0 immediately; no mem_out_valid afterwards; next request is served normally.
- Single write then read, RDLATENCY=0: mem_wrreq, addr 0x80, data 0x0fff0001, burstlen 1 -> at T+1 sram_we=1, sram_addr=0x20, mem_wr_ack=1. Then read 0x80, burstlen 1 -> mem_out=0x0fff0001 valid at T+2; mem_busy low next cycle.
- 8-word write burst at 0x180 with data 0x0fff1001..0x0fff1008, mem_wrreq dropped for 2 cycles after word 3 -> exactly 8 acks, no writes during the stall. 8-word read back with RDLATENCY=2 -> 8 consecutive valids, first at T+4, data in order.
- Wrap: 4-word write at byte address 0x7f8 (word 0x1fe), SRAM_ADDRBITS=9 -> SRAM words 0x1fe, 0x1ff, 0x000, 0x001 written.
- Simultaneous mem_rdreq and mem_wrreq in IDLE -> write burst executes and no read valid appears. mem_burstlen=0 -> exactly one word transferred.
- Requests while busy: mem_rdreq pulsed during DRAIN -> ignored; mem_out_valid count equals the original burstlen only.
